// File: rtl/rv_ctl_hs.sv
// rv_ctl_hs: multicycle RV32-subset control FSM with a memory ready/req handshake,
// sticky illegal/timeout flags and a retired-instruction counter.
module rv_ctl_hs #(
    parameter int unsigned MEM_TMO = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memrw,
    output logic [1:0]       pcsource,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic             mdrwrite,
    output logic             regwen,
    output logic [1:0]       wbsel,
    output logic [2:0]       immsel,
    output logic [1:0]       asel,
    output logic [1:0]       bsel,
    output logic [3:0]       alusel,
    output logic             illegal,
    output logic             timeout,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);
    localparam int unsigned WAIT_W = $clog2(MEM_TMO + 1) + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] PC_ALU     = 2'd1;
    localparam logic [1:0] PC_ALU_CLR = 2'd2;
    localparam logic [1:0] WB_PC      = 2'd0;
    localparam logic [1:0] WB_ALU     = 2'd1;
    localparam logic [1:0] WB_MDR     = 2'd2;
    localparam logic [2:0] IMM_I      = 3'd0;
    localparam logic [2:0] IMM_S      = 3'd1;
    localparam logic [2:0] IMM_B      = 3'd2;
    localparam logic [2:0] IMM_J      = 3'd3;
    localparam logic [2:0] IMM_U      = 3'd4;
    localparam logic [1:0] A_REG      = 2'd0;
    localparam logic [1:0] A_PCC      = 2'd1;
    localparam logic [1:0] A_ZERO     = 2'd2;
    localparam logic [1:0] B_REG      = 2'd0;
    localparam logic [1:0] B_IMM      = 2'd1;
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;

    typedef enum logic [3:0] {
        FETCH, DECODE, ADDR, MEM_RD, MEM_WB, MEM_WR,
        ALU_EXEC, ALU_WB, BRANCH, JAL_EX, JALR_EX, HALT
    } state_t;

    state_t             state, state_n;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instret_q;
    logic               illegal_q, timeout_q;
    logic               set_illegal, set_timeout, retire;
    logic               mem_state, wait_last;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_lw, is_sw, is_opimm, is_op, is_lui, is_br, is_jal, is_jalr;
    logic       unused_instr;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_lw    = (opcode == OPC_LOAD)  && (funct3 == 3'b010);
    assign is_sw    = (opcode == OPC_STORE) && (funct3 == 3'b010);
    assign is_opimm = (opcode == OPC_OPIMM);
    assign is_op    = (opcode == OPC_OP);
    assign is_lui   = (opcode == OPC_LUI);
    assign is_br    = (opcode == OPC_BRANCH) && (funct3[2:1] == 2'b00);
    assign is_jal   = (opcode == OPC_JAL);
    assign is_jalr  = (opcode == OPC_JALR) && (funct3 == 3'b000);
    assign unused_instr = &{1'b0, instr[31], instr[29:15], instr[11:7]};

    assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // This cycle would push the wait count to MEM_TMO without a response.
    assign wait_last = (MEM_TMO != 0) && (32'(wait_cnt) == (MEM_TMO - 32'd1));

    always_comb begin
        state_n     = state;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        mem_req     = 1'b0;
        memrw       = 1'b0;
        pcsource    = 2'd0;
        pcwrite     = 1'b0;
        pccen       = 1'b0;
        irwrite     = 1'b0;
        mdrwrite    = 1'b0;
        regwen      = 1'b0;
        wbsel       = WB_PC;
        immsel      = IMM_I;
        asel        = A_REG;
        bsel        = B_REG;
        alusel      = ALU_ADD;
        halted      = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    pccen   = 1'b1;
                    state_n = DECODE;
                end else if (wait_last) begin
                    mem_req     = 1'b0;
                    set_timeout = 1'b1;
                    state_n     = HALT;
                end
            end
            DECODE: begin
                immsel = IMM_B;
                asel   = A_PCC;
                bsel   = B_IMM;
                if (is_lw || is_sw || is_opimm) state_n = ADDR;
                else if (is_op || is_lui)       state_n = ALU_EXEC;
                else if (is_br)                 state_n = BRANCH;
                else if (is_jal)                state_n = JAL_EX;
                else if (is_jalr)               state_n = JALR_EX;
                else begin
                    set_illegal = 1'b1;
                    state_n     = HALT;
                end
            end
            ADDR: begin
                bsel   = B_IMM;
                immsel = is_sw ? IMM_S : IMM_I;
                if (is_opimm && (funct3 == 3'b101)) alusel = {funct3, instr[30]};
                if (is_lw)      state_n = MEM_RD;
                else if (is_sw) state_n = MEM_WR;
                else            state_n = ALU_WB;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    mdrwrite = 1'b1;
                    state_n  = MEM_WB;
                end else if (wait_last) begin
                    mem_req     = 1'b0;
                    set_timeout = 1'b1;
                    state_n     = HALT;
                end
            end
            MEM_WR: begin
                mem_req = 1'b1;
                memrw   = 1'b1;
                if (mem_ready) begin
                    state_n = FETCH;
                end else if (wait_last) begin
                    mem_req     = 1'b0;
                    memrw       = 1'b0;
                    set_timeout = 1'b1;
                    state_n     = HALT;
                end
            end
            MEM_WB: begin
                regwen  = 1'b1;
                wbsel   = WB_MDR;
                state_n = FETCH;
            end
            ALU_EXEC: begin
                if (is_lui) begin
                    asel   = A_ZERO;
                    bsel   = B_IMM;
                    immsel = IMM_U;
                end else begin
                    alusel = {funct3, instr[30]};
                end
                state_n = ALU_WB;
            end
            ALU_WB: begin
                regwen  = 1'b1;
                wbsel   = WB_ALU;
                state_n = FETCH;
            end
            BRANCH: begin
                alusel   = ALU_SUB;
                pcsource = PC_ALU;
                pcwrite  = (funct3[0] == 1'b0) ? zero : ~zero;
                state_n  = FETCH;
            end
            JAL_EX: begin
                asel     = A_PCC;
                bsel     = B_IMM;
                immsel   = IMM_J;
                pcsource = PC_ALU;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                wbsel    = WB_PC;
                state_n  = FETCH;
            end
            JALR_EX: begin
                bsel     = B_IMM;
                pcsource = PC_ALU_CLR;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                wbsel    = WB_PC;
                state_n  = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_n = HALT;
        endcase

        retire  = (state != FETCH) && (state_n == FETCH);
        illegal = illegal_q;
        timeout = timeout_q;
        instret = instret_q;

        // Reset silences every output in the cycle it is applied.
        if (rst) begin
            set_illegal = 1'b0;
            set_timeout = 1'b0;
            retire      = 1'b0;
            mem_req     = 1'b0;
            memrw       = 1'b0;
            pcsource    = 2'd0;
            pcwrite     = 1'b0;
            pccen       = 1'b0;
            irwrite     = 1'b0;
            mdrwrite    = 1'b0;
            regwen      = 1'b0;
            wbsel       = 2'd0;
            immsel      = 3'd0;
            asel        = 2'd0;
            bsel        = 2'd0;
            alusel      = 4'd0;
            halted      = 1'b0;
            illegal     = 1'b0;
            timeout     = 1'b0;
            instret     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_n;
    end

    // Wait counter restarts on entry to any state that waits on memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_n != state) &&
                     ((state_n == FETCH) || (state_n == MEM_RD) || (state_n == MEM_WR))) begin
            wait_cnt <= '0;
        end else if (mem_state && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (retire)      instret_q <= instret_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv_ctl_hs.sv
// Directed-vector bench for rv_ctl_hs: per-cycle expected control words queued
// by the stimulus, popped and compared by an independent negedge monitor.
module tb_rv_ctl_hs;
    typedef struct packed {
        logic       mem_req;
        logic       memrw;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic       mdrwrite;
        logic       regwen;
        logic [1:0] wbsel;
        logic [2:0] immsel;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [3:0] alusel;
        logic       illegal;
        logic       timeout;
        logic       halted;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [31:0] n;
        string       tag;
    } exp_t;

    localparam ctl_t C_ZERO     = '{default: '0};
    localparam ctl_t C_REQ      = '{mem_req: 1'b1, default: '0};
    localparam ctl_t C_FD       = '{mem_req: 1'b1, pcwrite: 1'b1, pccen: 1'b1, irwrite: 1'b1, default: '0};
    localparam ctl_t C_DEC      = '{immsel: 3'd2, asel: 2'd1, bsel: 2'd1, default: '0};
    localparam ctl_t C_ADDR_I   = '{bsel: 2'd1, default: '0};
    localparam ctl_t C_ADDR_S   = '{bsel: 2'd1, immsel: 3'd1, default: '0};
    localparam ctl_t C_SRAI     = '{bsel: 2'd1, alusel: 4'b1011, default: '0};
    localparam ctl_t C_SUB      = '{alusel: 4'b0001, default: '0};
    localparam ctl_t C_LUI      = '{asel: 2'd2, bsel: 2'd1, immsel: 3'd4, default: '0};
    localparam ctl_t C_ALUWB    = '{regwen: 1'b1, wbsel: 2'd1, default: '0};
    localparam ctl_t C_MEMRD    = '{mem_req: 1'b1, mdrwrite: 1'b1, default: '0};
    localparam ctl_t C_MEMWB    = '{regwen: 1'b1, wbsel: 2'd2, default: '0};
    localparam ctl_t C_MEMWR    = '{mem_req: 1'b1, memrw: 1'b1, default: '0};
    localparam ctl_t C_BR_T     = '{alusel: 4'b0001, pcsource: 2'd1, pcwrite: 1'b1, default: '0};
    localparam ctl_t C_BR_N     = '{alusel: 4'b0001, pcsource: 2'd1, default: '0};
    localparam ctl_t C_JAL      = '{asel: 2'd1, bsel: 2'd1, immsel: 3'd3, pcsource: 2'd1,
                                    pcwrite: 1'b1, regwen: 1'b1, default: '0};
    localparam ctl_t C_JALR     = '{bsel: 2'd1, pcsource: 2'd2, pcwrite: 1'b1, regwen: 1'b1, default: '0};
    localparam ctl_t C_HALT_TMO = '{halted: 1'b1, timeout: 1'b1, default: '0};
    localparam ctl_t C_HALT_ILL = '{halted: 1'b1, illegal: 1'b1, default: '0};

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_LW   = 32'h0000_A103;
    localparam logic [31:0] I_SW   = 32'h0020_A223;
    localparam logic [31:0] I_SRAI = 32'h4020_D193;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_LUI  = 32'h1234_5237;
    localparam logic [31:0] I_BNE  = 32'h0020_9063;
    localparam logic [31:0] I_BEQ  = 32'h0020_8063;
    localparam logic [31:0] I_JAL  = 32'h0000_00EF;
    localparam logic [31:0] I_JALR = 32'h0000_8067;
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, memrw, pcwrite, pccen, irwrite, mdrwrite, regwen;
    logic [1:0]  pcsource, wbsel, asel, bsel;
    logic [2:0]  immsel;
    logic [3:0]  alusel;
    logic        illegal, timeout, halted;
    logic [31:0] instret;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    ctl_t mon_a;

    rv_ctl_hs #(.MEM_TMO(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memrw(memrw), .pcsource(pcsource), .pcwrite(pcwrite),
        .pccen(pccen), .irwrite(irwrite), .mdrwrite(mdrwrite), .regwen(regwen),
        .wbsel(wbsel), .immsel(immsel), .asel(asel), .bsel(bsel), .alusel(alusel),
        .illegal(illegal), .timeout(timeout), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    // Monitor: one expected word per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            mon_a.mem_req  = mem_req;
            mon_a.memrw    = memrw;
            mon_a.pcsource = pcsource;
            mon_a.pcwrite  = pcwrite;
            mon_a.pccen    = pccen;
            mon_a.irwrite  = irwrite;
            mon_a.mdrwrite = mdrwrite;
            mon_a.regwen   = regwen;
            mon_a.wbsel    = wbsel;
            mon_a.immsel   = immsel;
            mon_a.asel     = asel;
            mon_a.bsel     = bsel;
            mon_a.alusel   = alusel;
            mon_a.illegal  = illegal;
            mon_a.timeout  = timeout;
            mon_a.halted   = halted;
            checks++;
            if (mon_a !== mon_e.c) begin
                failures++;
                $display("FAIL %s ctl: got %07h want %07h", mon_e.tag, mon_a, mon_e.c);
            end
            checks++;
            if (instret !== mon_e.n) begin
                failures++;
                $display("FAIL %s instret: got %0d want %0d", mon_e.tag, instret, mon_e.n);
            end
        end
    end

    task automatic step(input logic r, input logic [31:0] i, input logic z, input logic mr,
                        input ctl_t c, input logic [31:0] n, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        instr     = i;
        zero      = z;
        mem_ready = mr;
        e.c   = c;
        e.n   = n;
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        step(1'b1, '0, 1'b0, 1'b0, C_ZERO, 0, "rst0");

        step(1'b0, I_ADDI, 1'b0, 1'b1, C_FD,     0, "addi.f");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_DEC,    0, "addi.d");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_ADDR_I, 0, "addi.a");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_ALUWB,  0, "addi.wb");

        for (int k = 0; k < 3; k++) step(1'b0, I_LW, 1'b0, 1'b0, C_REQ, 1, "lw.fwait");
        step(1'b0, I_LW, 1'b0, 1'b1, C_FD,     1, "lw.f");
        step(1'b0, I_LW, 1'b0, 1'b1, C_DEC,    1, "lw.d");
        step(1'b0, I_LW, 1'b0, 1'b0, C_ADDR_I, 1, "lw.a");
        step(1'b0, I_LW, 1'b0, 1'b0, C_REQ,    1, "lw.rwait");
        step(1'b0, I_LW, 1'b0, 1'b1, C_MEMRD,  1, "lw.rd");
        step(1'b0, I_LW, 1'b0, 1'b1, C_MEMWB,  1, "lw.wb");

        step(1'b0, I_SW, 1'b0, 1'b1, C_FD,     2, "sw.f");
        step(1'b0, I_SW, 1'b0, 1'b1, C_DEC,    2, "sw.d");
        step(1'b0, I_SW, 1'b0, 1'b1, C_ADDR_S, 2, "sw.a");
        step(1'b0, I_SW, 1'b0, 1'b1, C_MEMWR,  2, "sw.wr");

        step(1'b0, I_SRAI, 1'b0, 1'b1, C_FD,    3, "srai.f");
        step(1'b0, I_SRAI, 1'b0, 1'b0, C_DEC,   3, "srai.d");
        step(1'b0, I_SRAI, 1'b0, 1'b0, C_SRAI,  3, "srai.a");
        step(1'b0, I_SRAI, 1'b0, 1'b0, C_ALUWB, 3, "srai.wb");

        step(1'b0, I_SUB, 1'b0, 1'b1, C_FD,    4, "sub.f");
        step(1'b0, I_SUB, 1'b0, 1'b1, C_DEC,   4, "sub.d");
        step(1'b0, I_SUB, 1'b0, 1'b1, C_SUB,   4, "sub.ex");
        step(1'b0, I_SUB, 1'b0, 1'b1, C_ALUWB, 4, "sub.wb");

        step(1'b0, I_LUI, 1'b0, 1'b1, C_FD,    5, "lui.f");
        step(1'b0, I_LUI, 1'b0, 1'b1, C_DEC,   5, "lui.d");
        step(1'b0, I_LUI, 1'b0, 1'b1, C_LUI,   5, "lui.ex");
        step(1'b0, I_LUI, 1'b0, 1'b1, C_ALUWB, 5, "lui.wb");

        step(1'b0, I_BNE, 1'b0, 1'b1, C_FD,   6, "bne0.f");
        step(1'b0, I_BNE, 1'b0, 1'b1, C_DEC,  6, "bne0.d");
        step(1'b0, I_BNE, 1'b0, 1'b1, C_BR_T, 6, "bne0.br");
        step(1'b0, I_BNE, 1'b1, 1'b1, C_FD,   7, "bne1.f");
        step(1'b0, I_BNE, 1'b1, 1'b1, C_DEC,  7, "bne1.d");
        step(1'b0, I_BNE, 1'b1, 1'b1, C_BR_N, 7, "bne1.br");
        step(1'b0, I_BEQ, 1'b1, 1'b1, C_FD,   8, "beq1.f");
        step(1'b0, I_BEQ, 1'b1, 1'b1, C_DEC,  8, "beq1.d");
        step(1'b0, I_BEQ, 1'b1, 1'b1, C_BR_T, 8, "beq1.br");
        step(1'b0, I_BEQ, 1'b0, 1'b1, C_FD,   9, "beq0.f");
        step(1'b0, I_BEQ, 1'b0, 1'b1, C_DEC,  9, "beq0.d");
        step(1'b0, I_BEQ, 1'b0, 1'b1, C_BR_N, 9, "beq0.br");

        step(1'b0, I_JAL,  1'b0, 1'b1, C_FD,   10, "jal.f");
        step(1'b0, I_JAL,  1'b0, 1'b1, C_DEC,  10, "jal.d");
        step(1'b0, I_JAL,  1'b0, 1'b1, C_JAL,  10, "jal.ex");
        step(1'b0, I_JALR, 1'b0, 1'b1, C_FD,   11, "jalr.f");
        step(1'b0, I_JALR, 1'b0, 1'b1, C_DEC,  11, "jalr.d");
        step(1'b0, I_JALR, 1'b0, 1'b1, C_JALR, 11, "jalr.ex");

        // Store answered on the last allowed wait cycle.
        step(1'b0, I_SW, 1'b0, 1'b1, C_FD,     12, "swl.f");
        step(1'b0, I_SW, 1'b0, 1'b1, C_DEC,    12, "swl.d");
        step(1'b0, I_SW, 1'b0, 1'b1, C_ADDR_S, 12, "swl.a");
        for (int k = 0; k < 3; k++) step(1'b0, I_SW, 1'b0, 1'b0, C_MEMWR, 12, "swl.wait");
        step(1'b0, I_SW, 1'b0, 1'b1, C_MEMWR,  12, "swl.wr");

        // Store never answered: timeout then absorbing HALT.
        step(1'b0, I_SW, 1'b0, 1'b1, C_FD,     13, "swt.f");
        step(1'b0, I_SW, 1'b0, 1'b1, C_DEC,    13, "swt.d");
        step(1'b0, I_SW, 1'b0, 1'b1, C_ADDR_S, 13, "swt.a");
        for (int k = 0; k < 3; k++) step(1'b0, I_SW, 1'b0, 1'b0, C_MEMWR, 13, "swt.wait");
        step(1'b0, I_SW, 1'b0, 1'b0, C_ZERO,   13, "swt.tmo");
        step(1'b0, I_SW, 1'b0, 1'b1, C_HALT_TMO, 13, "swt.halt0");
        step(1'b0, I_SW, 1'b0, 1'b1, C_HALT_TMO, 13, "swt.halt1");

        step(1'b1, I_SW,  1'b0, 1'b1, C_ZERO, 0, "rst1");
        step(1'b0, I_BAD, 1'b0, 1'b0, C_REQ,  0, "bad.fwait");
        step(1'b0, I_BAD, 1'b0, 1'b1, C_FD,   0, "bad.f");
        step(1'b0, I_BAD, 1'b0, 1'b1, C_DEC,  0, "bad.d");
        step(1'b0, I_BAD, 1'b0, 1'b1, C_HALT_ILL, 0, "bad.halt0");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_HALT_ILL, 0, "bad.halt1");

        step(1'b1, I_ADDI, 1'b0, 1'b1, C_ZERO,   0, "rst2");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_FD,     0, "addi2.f");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_DEC,    0, "addi2.d");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_ADDR_I, 0, "addi2.a");
        step(1'b0, I_ADDI, 1'b0, 1'b1, C_ALUWB,  0, "addi2.wb");
        step(1'b0, I_LW,   1'b0, 1'b1, C_FD,     1, "lw2.f");
        step(1'b0, I_LW,   1'b0, 1'b1, C_DEC,    1, "lw2.d");
        step(1'b0, I_LW,   1'b0, 1'b1, C_ADDR_I, 1, "lw2.a");
        step(1'b0, I_LW,   1'b0, 1'b0, C_REQ,    1, "lw2.rwait0");
        step(1'b0, I_LW,   1'b0, 1'b0, C_REQ,    1, "lw2.rwait1");
        step(1'b1, I_LW,   1'b0, 1'b1, C_ZERO,   0, "rst3");
        for (int k = 0; k < 3; k++) step(1'b0, I_LW, 1'b0, 1'b0, C_REQ, 0, "lw3.fwait");
        step(1'b0, I_LW,   1'b0, 1'b1, C_FD,     0, "lw3.f");
        step(1'b0, I_LW,   1'b0, 1'b1, C_DEC,    0, "lw3.d");

        for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected words left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
